decode_stage_pipelined: RTL and testbench
=========================================

# decode_stage_pipelined

Parametrised successor to the decode stage: instruction field extraction, a 2^REG_ADDR_W-entry register file, load-use hazard detection and a registered ID/EX output latch, all in one block. It sits between the IF/ID latch and execute. It adds three behaviours: flush-to-bubble, an optional WB-to-ID bypass, and a drain-then-halt state machine for the stop-pipe request.

## Interface
- DATA_W, 32, register and immediate width (≥16)
- REG_ADDR_W, 5, register address width; register count = 2^REG_ADDR_W
- PC_W, 32, program counter width
- DRAIN_CYCLES, 3, bubble cycles emitted after a stop request before halting (1..15)

- clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  IF/ID holds a real instruction
- i_instruction  in  32  MIPS-format word: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0]
- i_pc  in  PC_W  PC of the instruction
- i_wb_we / i_wb_addr / i_wb_data  in  1 / REG_ADDR_W / DATA_W  writeback port
- i_ex_memread / i_ex_rt  in  1 / REG_ADDR_W  ID/EX load info for the hazard check
- i_flush  in  1  squash the current decode slot (branch taken)
- i_stop_pipe  in  1  halt request
- i_dbg_addr  in  REG_ADDR_W  debug read index
- o_valid, o_pc, o_op[6], o_funct[6], o_rs_addr, o_rt_addr, o_rd_addr, o_rs_data, o_rt_data, o_imm_ext[DATA_W]  out  registered ID/EX payload
- o_regwrite, o_memread, o_memwrite, o_memtoreg  out  1 each  registered control
- o_pc_write, o_if_id_write, o_stall  out  1 each  combinational hazard outputs
- o_halted  out  1  pipeline halted
- o_dbg_data  out  DATA_W  combinational read of register i_dbg_addr

## Operation

**Register file**
- Register 0 reads zero. Writes to address 0 are dropped.
- A write occurs on the rising edge when i_wb_we=1.
- Reads on rs, rt and dbg are combinational.

**Immediate**
- o_imm_ext is imm[15:0] sign-extended to DATA_W.

**Control decode**
- op=0: regwrite.
- op[5:3]=3'b001: regwrite.
- op[5:3]=3'b100: memread, memtoreg, regwrite.
- op[5:3]=3'b101: memwrite.
- Any other op: all control bits 0.

**Hazard**
- stall = i_valid & i_ex_memread & (i_ex_rt≠0) & (i_ex_rt==rs | i_ex_rt==rt) & ~i_flush.
- o_stall = stall.
- o_pc_write and o_if_id_write = ~stall & (state==RUN).

**Latch load (per edge)**
- A bubble is loaded if any of these hold: stall, i_flush, ~i_valid, or state≠RUN.
- A bubble means o_valid=0 and all control bits 0. Payload fields are don't-care, but a bubble loads zeros.
- Otherwise the latch loads the decoded instruction with o_valid=1.

**State machine**
- RUN: if i_stop_pipe=1, go to DRAIN and load counter=DRAIN_CYCLES−1. The instruction in the decode slot that cycle is still decoded normally unless stall or flush applies.
- DRAIN: emit bubbles; decrement the counter; go to HALTED when the counter is 0.
- HALTED: o_halted=1 and bubbles only. Left only through reset.
- i_flush and i_stop_pipe are ignored outside RUN.
- Writeback writes are accepted in every state, so in-flight instructions still retire.

**Reset (asynchronous, immediate)**
- All latch outputs 0.
- All registers 0.
- State RUN, counter 0, o_halted=0.
- Reset asserted mid-DRAIN or in HALTED returns to RUN.

## Timing
- Decode latency: 1 cycle, from an instruction at IF/ID to its fields on the latch outputs.
- o_stall, o_pc_write and o_if_id_write are valid in the same cycle from the inputs, with no register in the path.
- Load-use stall lasts exactly 1 cycle. The next cycle, ID/EX holds a bubble, so i_ex_memread=0.
- A writeback write is visible to a same-cycle decode read only with the bypass (see Configuration). Without the bypass it is visible from the next cycle.
- Stop timing: i_stop_pipe sampled at edge N gives o_halted=1 after edge N+DRAIN_CYCLES.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - rs/rt/dbg reads return i_wb_data when i_wb_we=1, the address matches, and the address is nonzero.
  - This gives same-cycle write-through.
- Undefined:
  - Reads return only the stored value.
  - The writeback stage must then write one cycle earlier, or the hazard logic must cover the gap.

## Test plan
- Reset with all registers loaded → o_valid=0, o_rs_data=0, o_dbg_data=0 for every index, o_halted=0, o_pc_write=1.
- Write reg 5 = 0xDEADBEEF, then decode `add` rs=5 rt=0 at pc=0x40 → the next cycle shows o_valid=1, o_rs_data=0xDEADBEEF, o_rt_data=0, o_regwrite=1, o_pc=0x40.
- With i_ex_memread=1, i_ex_rt=5, decode rs=5 → o_stall=1, o_pc_write=0, o_if_id_write=0, the next latch holds a bubble. The same case with i_ex_rt=0 gives no stall.
- Same-cycle write reg 7=0x1234 and decode rs=7 → o_rs_data=0x1234 with DECODE_WB_BYPASS_EN defined, and the old value without it. Write to reg 0 → reads stay 0.
- Stall and i_flush asserted together → o_stall=0, the latch loads a bubble.
- Imm 0x8001 → o_imm_ext=0xFFFF8001. Imm 0x7FFF → 0x00007FFF.
- i_stop_pipe pulse with DRAIN_CYCLES=3:
  - the decode-slot instruction latches,
  - 3 bubbles follow,
  - o_halted=1 and pc_write=0 thereafter,
  - writeback writes still land,
  - i_reset mid-DRAIN returns to RUN with o_halted=0.

Source files
------------

// File: rtl/decode_stage_pipelined.sv
// ID stage: field extraction, register file, load-use hazard check, ID/EX latch and stop/drain/halt FSM.
// Optional WB-to-ID write-through is enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage_pipelined #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int PC_W         = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [31:0]           i_instruction,
  input  logic [PC_W-1:0]       i_pc,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0]     i_wb_data,
  input  logic                  i_ex_memread,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic                  i_flush,
  input  logic                  i_stop_pipe,
  input  logic [REG_ADDR_W-1:0] i_dbg_addr,
  output logic                  o_valid,
  output logic [PC_W-1:0]       o_pc,
  output logic [5:0]            o_op,
  output logic [5:0]            o_funct,
  output logic [REG_ADDR_W-1:0] o_rs_addr,
  output logic [REG_ADDR_W-1:0] o_rt_addr,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0]     o_rs_data,
  output logic [DATA_W-1:0]     o_rt_data,
  output logic [DATA_W-1:0]     o_imm_ext,
  output logic                  o_regwrite,
  output logic                  o_memread,
  output logic                  o_memwrite,
  output logic                  o_memtoreg,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_stall,
  output logic                  o_halted,
  output logic [DATA_W-1:0]     o_dbg_data
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op[5:3])
      3'b000: c.regwrite = (op[2:0] == 3'b000);
      3'b001: c.regwrite = 1'b1;
      3'b100: begin
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      3'b101: c.memwrite = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] imm);
    return DATA_W'($signed(imm));
  endfunction

  logic [DATA_W-1:0]     regs_q [NREG];
  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  halted_q;

  logic [REG_ADDR_W-1:0] rs_addr_s, rt_addr_s, rd_addr_s;
  logic [DATA_W-1:0]     rs_data_s, rt_data_s, dbg_data_s;
  logic                  stall_s, bubble_s;
  ctrl_t                 ctrl_s;
  logic                  unused_shamt_s;

  logic                  valid_q, valid_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [5:0]            op_q, op_d, funct_q, funct_d;
  logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  ctrl_t                 ctrl_q, ctrl_d;

  assign rs_addr_s      = REG_ADDR_W'(i_instruction[25:21]);
  assign rt_addr_s      = REG_ADDR_W'(i_instruction[20:16]);
  assign rd_addr_s      = REG_ADDR_W'(i_instruction[15:11]);
  assign unused_shamt_s = ^i_instruction[10:6];
  assign ctrl_s         = decode_ctrl(i_instruction[31:26]);

  // Register file write port; address 0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= '0;
      end
    end else if (i_wb_we && (i_wb_addr != '0)) begin
      regs_q[i_wb_addr] <= i_wb_data;
    end else begin
      regs_q <= regs_q;
    end
  end

  // Combinational read ports, with optional same-cycle write-through from writeback.
  always_comb begin
    rs_data_s  = '0;
    rt_data_s  = '0;
    dbg_data_s = '0;
`ifdef DECODE_WB_BYPASS_EN
    if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == rs_addr_s)) begin
      rs_data_s = i_wb_data;
    end else begin
      rs_data_s = (rs_addr_s == '0) ? '0 : regs_q[rs_addr_s];
    end
    if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == rt_addr_s)) begin
      rt_data_s = i_wb_data;
    end else begin
      rt_data_s = (rt_addr_s == '0) ? '0 : regs_q[rt_addr_s];
    end
    if (i_wb_we && (i_wb_addr != '0) && (i_wb_addr == i_dbg_addr)) begin
      dbg_data_s = i_wb_data;
    end else begin
      dbg_data_s = (i_dbg_addr == '0) ? '0 : regs_q[i_dbg_addr];
    end
`else
    rs_data_s  = (rs_addr_s == '0) ? '0 : regs_q[rs_addr_s];
    rt_data_s  = (rt_addr_s == '0) ? '0 : regs_q[rt_addr_s];
    dbg_data_s = (i_dbg_addr == '0) ? '0 : regs_q[i_dbg_addr];
`endif
  end

  // Load-use hazard; a flush already kills the slot so it must not also freeze fetch.
  assign stall_s = i_valid & i_ex_memread & (i_ex_rt != '0) &
                   ((i_ex_rt == rs_addr_s) | (i_ex_rt == rt_addr_s)) & ~i_flush;
  assign bubble_s = stall_s | i_flush | ~i_valid | (state_q != ST_RUN);

  assign o_stall       = stall_s;
  assign o_pc_write    = ~stall_s & (state_q == ST_RUN);
  assign o_if_id_write = ~stall_s & (state_q == ST_RUN);
  assign o_dbg_data    = dbg_data_s;

  // Next ID/EX contents: decoded instruction, or an all-zero bubble.
  always_comb begin
    valid_d   = 1'b0;
    pc_d      = '0;
    op_d      = '0;
    funct_d   = '0;
    rs_addr_d = '0;
    rt_addr_d = '0;
    rd_addr_d = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    ctrl_d    = '0;
    if (!bubble_s) begin
      valid_d   = 1'b1;
      pc_d      = i_pc;
      op_d      = i_instruction[31:26];
      funct_d   = i_instruction[5:0];
      rs_addr_d = rs_addr_s;
      rt_addr_d = rt_addr_s;
      rd_addr_d = rd_addr_s;
      rs_data_d = rs_data_s;
      rt_data_d = rt_data_s;
      imm_d     = sign_ext16(i_instruction[15:0]);
      ctrl_d    = ctrl_s;
    end else begin
      valid_d   = 1'b0;
    end
  end

  // ID/EX pipeline latch.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      op_q      <= '0;
      funct_q   <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Stop request: drain DRAIN_CYCLES bubbles, then halt until reset.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_RUN;
      cnt_q    <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (i_stop_pipe) begin
            state_q <= ST_DRAIN;
            cnt_q   <= DRAIN_LOAD;
          end else begin
            state_q <= ST_RUN;
          end
          halted_q <= 1'b0;
        end
        ST_DRAIN: begin
          if (cnt_q == 4'd0) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            cnt_q    <= cnt_q - 4'd1;
            halted_q <= 1'b0;
          end
        end
        ST_HALTED: begin
          state_q  <= ST_HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          cnt_q    <= 4'd0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid    = valid_q;
  assign o_pc       = pc_q;
  assign o_op       = op_q;
  assign o_funct    = funct_q;
  assign o_rs_addr  = rs_addr_q;
  assign o_rt_addr  = rt_addr_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rs_data  = rs_data_q;
  assign o_rt_data  = rt_data_q;
  assign o_imm_ext  = imm_q;
  assign o_regwrite = ctrl_q.regwrite;
  assign o_memread  = ctrl_q.memread;
  assign o_memwrite = ctrl_q.memwrite;
  assign o_memtoreg = ctrl_q.memtoreg;
  assign o_halted   = halted_q;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined: regfile, decode, hazards, bypass, drain/halt and reset.
module tb_decode_stage_pipelined;

  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_wb_we, i_ex_memread, i_flush, i_stop_pipe;
  logic [31:0] i_instruction, i_pc, i_wb_data;
  logic [4:0]  i_wb_addr, i_ex_rt, i_dbg_addr;
  logic        o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg;
  logic        o_pc_write, o_if_id_write, o_stall, o_halted;
  logic [31:0] o_pc, o_rs_data, o_rt_data, o_imm_ext, o_dbg_data;
  logic [5:0]  o_op, o_funct;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr;

  int checks = 0;
  int errors = 0;

  decode_stage_pipelined dut (
    .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_instruction(i_instruction),
    .i_pc(i_pc), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_ex_memread(i_ex_memread), .i_ex_rt(i_ex_rt), .i_flush(i_flush),
    .i_stop_pipe(i_stop_pipe), .i_dbg_addr(i_dbg_addr),
    .o_valid(o_valid), .o_pc(o_pc), .o_op(o_op), .o_funct(o_funct),
    .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr), .o_rd_addr(o_rd_addr),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext),
    .o_regwrite(o_regwrite), .o_memread(o_memread), .o_memwrite(o_memwrite),
    .o_memtoreg(o_memtoreg), .o_pc_write(o_pc_write), .o_if_id_write(o_if_id_write),
    .o_stall(o_stall), .o_halted(o_halted), .o_dbg_data(o_dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_instruction = 32'd0; i_pc = 32'd0;
    i_wb_we = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'd0;
    i_ex_memread = 1'b0; i_ex_rt = 5'd0; i_flush = 1'b0; i_stop_pipe = 1'b0;
    i_dbg_addr = 5'd0;
    tick();
    i_reset = 1'b0;

    // Load every register, then reset and confirm everything reads zero.
    for (int k = 1; k < 32; k++) begin
      i_wb_we = 1'b1; i_wb_addr = 5'(k); i_wb_data = 32'h1000_0000 + 32'(k);
      tick();
    end
    i_wb_we = 1'b0;
    i_dbg_addr = 5'd3; #1;
    check("dbg_loaded_r3", o_dbg_data, 32'h1000_0003);
    i_valid = 1'b1; i_instruction = r_type(5'd4, 5'd6, 5'd1, 6'h20); i_pc = 32'h10;
    tick();
    check("pre_reset_rs_data", o_rs_data, 32'h1000_0004);
    i_valid = 1'b0;
    i_reset = 1'b1; #1;
    check("rst_valid", o_valid, 32'd0);
    check("rst_rs_data", o_rs_data, 32'd0);
    check("rst_halted", o_halted, 32'd0);
    check("rst_pc_write", o_pc_write, 32'd1);
    for (int k = 0; k < 32; k++) begin
      i_dbg_addr = 5'(k); #1;
      check("rst_dbg_data", o_dbg_data, 32'd0);
    end
    tick();
    i_reset = 1'b0;

    // Write r5 then decode add rs=5 rt=0.
    i_wb_we = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hDEAD_BEEF;
    tick();
    i_wb_we = 1'b0;
    i_valid = 1'b1; i_instruction = r_type(5'd5, 5'd0, 5'd3, 6'h20); i_pc = 32'h40;
    tick();
    check("add_valid", o_valid, 32'd1);
    check("add_rs_data", o_rs_data, 32'hDEAD_BEEF);
    check("add_rt_data", o_rt_data, 32'd0);
    check("add_regwrite", o_regwrite, 32'd1);
    check("add_pc", o_pc, 32'h40);
    check("add_rs_addr", o_rs_addr, 32'd5);
    check("add_rd_addr", o_rd_addr, 32'd3);
    check("add_funct", o_funct, 32'h20);
    check("add_memread", o_memread, 32'd0);

    // Load-use stall on rs, then on rt, then no stall when ex_rt is r0.
    i_ex_memread = 1'b1; i_ex_rt = 5'd5; #1;
    check("lu_stall", o_stall, 32'd1);
    check("lu_pc_write", o_pc_write, 32'd0);
    check("lu_if_id_write", o_if_id_write, 32'd0);
    tick();
    check("lu_bubble_valid", o_valid, 32'd0);
    check("lu_bubble_regwrite", o_regwrite, 32'd0);
    i_instruction = r_type(5'd0, 5'd5, 5'd2, 6'h20); #1;
    check("lu_rt_stall", o_stall, 32'd1);
    i_ex_rt = 5'd0; #1;
    check("lu_r0_stall", o_stall, 32'd0);
    check("lu_r0_pc_write", o_pc_write, 32'd1);
    tick();
    check("lu_r0_valid", o_valid, 32'd1);
    check("lu_r0_rt_data", o_rt_data, 32'hDEAD_BEEF);
    i_ex_memread = 1'b0;

    // Same-cycle writeback to r7 while decoding rs=7.
    i_wb_we = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'h1234;
    i_instruction = r_type(5'd7, 5'd0, 5'd1, 6'h20); i_dbg_addr = 5'd7; #1;
`ifdef DECODE_WB_BYPASS_EN
    check("byp_dbg", o_dbg_data, 32'h1234);
    tick();
    check("byp_rs_data", o_rs_data, 32'h1234);
`else
    check("nobyp_dbg", o_dbg_data, 32'd0);
    tick();
    check("nobyp_rs_data", o_rs_data, 32'd0);
`endif
    i_wb_we = 1'b0;
    tick();
    check("r7_next_rs_data", o_rs_data, 32'h1234);

    // Writes to r0 are dropped.
    i_wb_we = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'hFFFF_FFFF;
    i_instruction = r_type(5'd0, 5'd0, 5'd1, 6'h20); i_dbg_addr = 5'd0; #1;
    check("r0_dbg_same", o_dbg_data, 32'd0);
    tick();
    check("r0_rs_data", o_rs_data, 32'd0);
    i_wb_we = 1'b0; #1;
    check("r0_dbg_after", o_dbg_data, 32'd0);

    // Stall condition together with flush: no stall, bubble loaded.
    i_ex_memread = 1'b1; i_ex_rt = 5'd7; i_flush = 1'b1;
    i_instruction = r_type(5'd7, 5'd0, 5'd1, 6'h20); #1;
    check("fl_stall", o_stall, 32'd0);
    check("fl_pc_write", o_pc_write, 32'd1);
    tick();
    check("fl_valid", o_valid, 32'd0);
    check("fl_regwrite", o_regwrite, 32'd0);
    i_ex_memread = 1'b0; i_ex_rt = 5'd0; i_flush = 1'b0;

    // Immediate extension and control decode for lw, sw, addi, jump.
    i_instruction = i_type(6'b100011, 5'd0, 5'd2, 16'h8001);
    tick();
    check("lw_imm", o_imm_ext, 32'hFFFF_8001);
    check("lw_ctrl", {o_regwrite, o_memread, o_memwrite, o_memtoreg}, 32'b1101);
    check("lw_op", o_op, 32'h23);
    i_instruction = i_type(6'b101011, 5'd0, 5'd2, 16'h7FFF);
    tick();
    check("sw_imm", o_imm_ext, 32'h0000_7FFF);
    check("sw_ctrl", {o_regwrite, o_memread, o_memwrite, o_memtoreg}, 32'b0010);
    i_instruction = i_type(6'b001000, 5'd0, 5'd2, 16'h0005);
    tick();
    check("addi_ctrl", {o_regwrite, o_memread, o_memwrite, o_memtoreg}, 32'b1000);
    i_instruction = i_type(6'b000010, 5'd0, 5'd0, 16'h0010);
    tick();
    check("j_ctrl", {o_regwrite, o_memread, o_memwrite, o_memtoreg}, 32'b0000);
    check("j_valid", o_valid, 32'd1);

    // Stop pulse: slot instruction latches, three bubbles, then halt.
    i_instruction = r_type(5'd5, 5'd0, 5'd3, 6'h20); i_pc = 32'h80; i_stop_pipe = 1'b1;
    tick();
    check("stop_slot_valid", o_valid, 32'd1);
    check("stop_slot_pc", o_pc, 32'h80);
    check("stop_halted_n", o_halted, 32'd0);
    i_stop_pipe = 1'b0;
    i_wb_we = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'hCAFE_0009; #1;
    check("drain_pc_write", o_pc_write, 32'd0);
    tick();
    i_wb_we = 1'b0; i_dbg_addr = 5'd9; #1;
    check("drain1_valid", o_valid, 32'd0);
    check("drain1_halted", o_halted, 32'd0);
    check("drain_wb_lands", o_dbg_data, 32'hCAFE_0009);
    tick();
    check("drain2_valid", o_valid, 32'd0);
    check("drain2_halted", o_halted, 32'd0);
    tick();
    check("drain3_valid", o_valid, 32'd0);
    check("halt_halted", o_halted, 32'd1);
    check("halt_pc_write", o_pc_write, 32'd0);
    check("halt_if_id_write", o_if_id_write, 32'd0);
    i_wb_we = 1'b1; i_wb_addr = 5'd10; i_wb_data = 32'hCAFE_000A;
    tick();
    i_wb_we = 1'b0; i_dbg_addr = 5'd10; #1;
    check("halt_wb_lands", o_dbg_data, 32'hCAFE_000A);
    check("halt_valid", o_valid, 32'd0);
    check("halt_stays", o_halted, 32'd1);

    // Reset out of HALTED, then reset in the middle of a drain.
    i_reset = 1'b1; #1;
    check("unhalt_halted", o_halted, 32'd0);
    check("unhalt_pc_write", o_pc_write, 32'd1);
    tick();
    i_reset = 1'b0;
    i_stop_pipe = 1'b1;
    tick();
    i_stop_pipe = 1'b0;
    tick();
    i_reset = 1'b1; #1;
    check("middrain_halted", o_halted, 32'd0);
    check("middrain_pc_write", o_pc_write, 32'd1);
    check("middrain_valid", o_valid, 32'd0);
    tick();
    i_reset = 1'b0;
    i_instruction = r_type(5'd0, 5'd0, 5'd3, 6'h20); i_pc = 32'hC0;
    tick();
    tick();
    tick();
    check("post_rst_valid", o_valid, 32'd1);
    check("post_rst_pc", o_pc, 32'hC0);
    check("post_rst_halted", o_halted, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
